// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit time-multiplexed 7-segment driver (ones/tens/hundreds + sign digit).
// Latency: an/seg registered (1 cycle); a loaded digit appears at that digit's next scan slot.
// Backpressure: none; load is a 1-cycle strobe that is always accepted. Optional blink: SEG7_CURSOR_BLINK_EN.
module seg7_scan_driver #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1_000,
  parameter int unsigned BLINK_HZ   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ones_in,
  input  logic [3:0] tens_in,
  input  logic [3:0] hundreds_in,
  input  logic       sign_in,
  input  logic [1:0] cursor,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // Cycles per digit slot; the last cycle of every slot is the dark ghost guard.
  localparam int unsigned SLOT = CLK_HZ / REFRESH_HZ;
  localparam int unsigned CW   = (SLOT > 1) ? $clog2(SLOT) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  // Prescaler and scan pointers. idx_q is the digit lit at the next slot start,
  // cur_q is the digit currently lit (its pattern frozen in pat_q).
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    cur_q, cur_d;
  logic          slot_end;

  // Shadow copies of the digit inputs.
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] hund_q, hund_d;
  logic       sign_q, sign_d;

  // Registered pin drivers and the pattern captured at slot start.
  logic [6:0] pat_q, pat_d;
  logic [6:0] sel_pat;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       blank_d;

  // BCD to active-low {g,f,e,d,c,b,a}; anything above 9 shows 'E'.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_ERR;
    endcase
    return s;
  endfunction

  // Shadow latch: capture all digit inputs on the load strobe, otherwise hold.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    hund_d = hund_q;
    sign_d = sign_q;
    if (load) begin
      ones_d = ones_in;
      tens_d = tens_in;
      hund_d = hundreds_in;
      sign_d = sign_in;
    end
  end

  // Scan sequencing: advance the digit at the end of each slot, blank anodes in the guard cycle.
  always_comb begin
    slot_end = (cnt_q == CW'(SLOT - 1));
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
    cur_d    = slot_end ? idx_q : cur_q;

    case (idx_q)
      2'd0:    sel_pat = bcd_to_seg(ones_q);
      2'd1:    sel_pat = bcd_to_seg(tens_q);
      2'd2:    sel_pat = bcd_to_seg(hund_q);
      default: sel_pat = sign_q ? SEG_MINUS : SEG_BLANK;
    endcase
    // Freeze the pattern for the whole slot so a mid-slot load waits for the next visit.
    pat_d = slot_end ? sel_pat : pat_q;

    an_d = an_q;
    if (slot_end) begin
      an_d = ~(4'b0001 << idx_q);
    end else if (cnt_d == CW'(SLOT - 1)) begin
      an_d = 4'b1111;
    end

    seg_d = blank_d ? SEG_BLANK : pat_d;
  end

`ifdef SEG7_CURSOR_BLINK_EN
  // Half-period of the cursor blink in clock cycles.
  localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;

  // Blink phase generator: toggle once per half-period.
  always_comb begin
    bcnt_d  = bcnt_q + BW'(1);
    blink_d = blink_q;
    if (bcnt_q == BW'(HALF - 1)) begin
      bcnt_d  = '0;
      blink_d = ~blink_q;
    end
  end

  // Blink state register; phase starts "shown" out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bcnt_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  // The digit under edit goes dark in the off phase; its anode keeps scanning.
  assign blank_d = !blink_d && (cursor == cur_d);
`else
  assign blank_d = 1'b0;

  // cursor and BLINK_HZ only matter when blinking is built in.
  logic unused_cfg;
  assign unused_cfg = ^{cursor, 32'(BLINK_HZ)};
`endif

  // Shadow register update; reset clears every digit and the sign.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ones_q <= '0;
      tens_q <= '0;
      hund_q <= '0;
      sign_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      hund_q <= hund_d;
      sign_q <= sign_d;
    end
  end

  // Scan state and pin registers; reset darkens the display and restarts at digit 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      cur_q <= 2'd0;
      pat_q <= SEG_BLANK;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      cur_q <= cur_d;
      pat_q <= pat_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized and directed stimulus against a frame-arithmetic display model.
// Latency: expectations are derived from the edge count since reset release.
// Backpressure: not applicable; inputs change on the falling edge, outputs sampled on the falling edge.
module tb_seg7_scan_driver;

  localparam int CLK_HZ     = 16;
  localparam int REFRESH_HZ = 4;
  localparam int BLINK_HZ   = 1;
  localparam int SLOT       = CLK_HZ / REFRESH_HZ;
  localparam int HALF       = CLK_HZ / (2 * BLINK_HZ);

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] ones_in, tens_in, hundreds_in;
  logic       sign_in;
  logic [1:0] cursor;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_driver #(
    .CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .BLINK_HZ(BLINK_HZ)
  ) dut (
    .clk(clk), .reset(reset), .load(load),
    .ones_in(ones_in), .tens_in(tens_in), .hundreds_in(hundreds_in),
    .sign_in(sign_in), .cursor(cursor),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Reference model: edges since reset, shadow digits, pattern frozen at each slot start.
  int         m_n;
  logic [3:0] m_sh [0:2];
  logic       m_sign;
  logic [6:0] m_pat;
  int         m_dig;
  logic       m_blink;
  logic [1:0] m_cur;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  always @(posedge clk) begin
    m_cur = cursor;
    if (!reset) begin
      m_n = 0; m_sh[0] = 4'd0; m_sh[1] = 4'd0; m_sh[2] = 4'd0; m_sign = 1'b0;
      m_pat = 7'h7F; m_dig = 0; m_blink = 1'b1;
    end else begin
      m_n++;
      if (m_n >= SLOT && (m_n - SLOT) % SLOT == 0) begin
        m_dig = ((m_n - SLOT) / SLOT) % 4;
        m_pat = (m_dig == 3) ? (m_sign ? 7'b0111111 : 7'b1111111) : glyph(m_sh[m_dig]);
      end
      m_blink = ((m_n / HALF) % 2) == 0;
      if (load) begin
        m_sh[0] = ones_in; m_sh[1] = tens_in; m_sh[2] = hundreds_in; m_sign = sign_in;
      end
    end
  end

  // Anodes: dark for the first slot after reset, then digit (slot mod 4) except the last cycle.
  function automatic logic [3:0] exp_an();
    logic [3:0] r;
    int m;
    r = 4'b1111;
    if (m_n >= SLOT) begin
      m = m_n - SLOT;
      if (m % SLOT != SLOT - 1) r[(m / SLOT) % 4] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg();
`ifdef SEG7_CURSOR_BLINK_EN
    if (!m_blink && m_cur == 2'(m_dig)) return 7'h7F;
`endif
    return m_pat;
  endfunction

  task automatic test_reset();
    logic [3:0] want;
    reset = 1'b0; load = 1'b1; ones_in = 4'd9; tens_in = 4'd9; hundreds_in = 4'd9; sign_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks += 3;
      if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
      if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %b want 1111111", seg); end
      if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
    end
    load = 1'b0; reset = 1'b1;
    for (int i = 1; i <= SLOT; i++) begin
      @(negedge clk);
      want = (i < SLOT) ? 4'hF : 4'hE;
      n_checks++;
      if (an !== want) begin n_fail++; $display("FAIL release_an cycle %0d: got %b want %b", i, an, want); end
    end
    // load while in reset must have been ignored: digit 0 shows 0
    n_checks++;
    if (seg !== 7'b1000000) begin n_fail++; $display("FAIL release_digit0: got %b want 1000000", seg); end
  endtask

  task automatic test_frame();
    int dark;
    logic [6:0] want;
    ones_in = 4'd3; tens_in = 4'd7; hundreds_in = 4'd1; sign_in = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    dark = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an()) begin n_fail++; $display("FAIL frame_an: got %b want %b", an, exp_an()); end
      if (exp_an() != 4'hF) begin
        n_checks++;
        if (seg !== exp_seg()) begin n_fail++; $display("FAIL frame_seg: got %b want %b", seg, exp_seg()); end
      end
      if (i >= 16) begin
        want = 7'h00;
        case (an)
          4'hE: want = 7'b0110000;
          4'hD: want = 7'b1111000;
          4'hB: want = 7'b1111001;
          4'h7: want = 7'b1111111;
          4'hF: dark++;
          default: begin n_fail++; $display("FAIL frame_onehot: got %b want one-hot-low", an); end
        endcase
        if (an != 4'hF && an != 4'h0) begin
          n_checks++;
          if (seg !== want) begin n_fail++; $display("FAIL frame_table an=%b: got %b want %b", an, seg, want); end
        end
      end
    end
    n_checks++;
    if (dark != 4) begin n_fail++; $display("FAIL frame_dark_cycles: got %0d want 4", dark); end
  endtask

  task automatic test_sign_invalid();
    sign_in = 1'b1; ones_in = 4'hC; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an()) begin n_fail++; $display("FAIL sign_an: got %b want %b", an, exp_an()); end
      if (exp_an() != 4'hF) begin
        n_checks++;
        if (seg !== exp_seg()) begin n_fail++; $display("FAIL sign_seg: got %b want %b", seg, exp_seg()); end
      end
      if (i >= 16 && an == 4'h7) begin
        n_checks++;
        if (seg !== 7'b0111111) begin n_fail++; $display("FAIL sign_minus: got %b want 0111111", seg); end
      end
      if (i >= 16 && an == 4'hE) begin
        n_checks++;
        if (seg !== 7'b0000110) begin n_fail++; $display("FAIL invalid_E: got %b want 0000110", seg); end
      end
    end
  endtask

  task automatic test_hold_midload();
    ones_in = 4'd5; tens_in = 4'd2; hundreds_in = 4'd8; sign_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an == 4'hE) begin
        n_checks++;
        if (seg !== 7'b0000110) begin n_fail++; $display("FAIL hold_ones: got %b want 0000110", seg); end
      end
    end
    for (int i = 0; i < 40; i++) begin
      if (exp_an() == 4'hD) break;
      @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (an !== 4'hD) begin n_fail++; $display("FAIL midload_wait: got %b want 1101", an); end
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (seg !== 7'b1111000) begin n_fail++; $display("FAIL midload_old_tens: got %b want 1111000", seg); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an()) begin n_fail++; $display("FAIL midload_an: got %b want %b", an, exp_an()); end
      if (exp_an() != 4'hF) begin
        n_checks++;
        if (seg !== exp_seg()) begin n_fail++; $display("FAIL midload_seg: got %b want %b", seg, exp_seg()); end
      end
      if (i < 4 && an == 4'hB) begin
        n_checks++;
        if (seg !== 7'b0000000) begin n_fail++; $display("FAIL midload_hundreds: got %b want 0000000", seg); end
      end
    end
  endtask

  task automatic test_reset_midscan();
    for (int i = 0; i < 40; i++) begin
      if (exp_an() == 4'hB) break;
      @(negedge clk);
    end
    n_checks++;
    if (an !== 4'hB) begin n_fail++; $display("FAIL midreset_wait: got %b want 1011", an); end
    reset = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (an !== 4'hF) begin n_fail++; $display("FAIL midreset_an: got %b want 1111", an); end
    if (seg !== 7'h7F) begin n_fail++; $display("FAIL midreset_seg: got %b want 1111111", seg); end
    reset = 1'b1;
    for (int i = 1; i <= SLOT + 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an()) begin n_fail++; $display("FAIL midreset_scan: got %b want %b", an, exp_an()); end
      if (i == SLOT) begin
        n_checks++;
        if (an !== 4'hE) begin n_fail++; $display("FAIL midreset_restart: got %b want 1110", an); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (an !== exp_an()) begin n_fail++; $display("FAIL random_an: got %b want %b", an, exp_an()); end
      if (dp !== 1'b1) begin n_fail++; $display("FAIL random_dp: got %b want 1", dp); end
      if (exp_an() != 4'hF) begin
        n_checks++;
        if (seg !== exp_seg()) begin n_fail++; $display("FAIL random_seg: got %b want %b", seg, exp_seg()); end
      end
      load        = ($urandom_range(0, 3) == 0);
      ones_in     = 4'($urandom_range(0, 15));
      tens_in     = 4'($urandom_range(0, 15));
      hundreds_in = 4'($urandom_range(0, 15));
      sign_in     = 1'($urandom_range(0, 1));
      cursor      = 2'($urandom_range(0, 3));
    end
    load = 1'b0;
  endtask

`ifdef SEG7_CURSOR_BLINK_EN
  task automatic test_blink();
    cursor = 2'd1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tens_in = 4'd6; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an()) begin n_fail++; $display("FAIL blink_an: got %b want %b", an, exp_an()); end
      if (exp_an() != 4'hF) begin
        n_checks++;
        if (seg !== exp_seg()) begin n_fail++; $display("FAIL blink_seg: got %b want %b", seg, exp_seg()); end
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b0; load = 1'b0; ones_in = 4'd0; tens_in = 4'd0; hundreds_in = 4'd0;
    sign_in = 1'b0; cursor = 2'd0;
    test_reset();
    test_frame();
    test_sign_invalid();
    test_hold_midload();
    test_reset_midscan();
    test_random();
`ifdef SEG7_CURSOR_BLINK_EN
    test_blink();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
